operand_feeder: RTL and testbench
=================================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter DEPTH, default 4, operand-pair FIFO depth (power of two, 2..16).
REQ-002 Parameter W, default 6, operand/result width.
REQ-003 CLK  input  1  sole clock, all state on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 enq_a  input  W  operand a from the upstream source.
REQ-006 enq_b  input  W  operand b from the upstream source.
REQ-007 EN_enq  input  1  push (enq_a, enq_b); legal only while RDY_enq=1.
REQ-008 RDY_enq  output  1  FIFO not full.
REQ-009 start_a  output  W  a of the pair being issued.
REQ-010 start_b  output  W  b of the pair being issued.
REQ-011 EN_start  output  1  fires the downstream start method.
REQ-012 RDY_start  input  1  downstream start ready.
REQ-013 variable__check_d  output  W  argument for the downstream check method.
REQ-014 EN_variable__check  output  1  fires the downstream check method.
REQ-015 variable__check  input  W  value returned by check.
REQ-016 RDY_variable__check  input  1  downstream check ready.
REQ-017 res_val  output  1  one-cycle pulse: res_data is valid.
REQ-018 res_data  output  W  captured check value.
REQ-019 issued_cnt  output  8  completed transactions, wraps 255->0.
REQ-020 mismatch  output  1  sticky self-check error.

Function
REQ-021 FIFO: circular buffer, DEPTH entries; RDY_enq=(occupancy<DEPTH), evaluated from registered occupancy only; a pop in the same cycle does not raise RDY_enq in that cycle.
REQ-022 Simultaneous push and pop when not full: occupancy unchanged, both take effect; pointers wrap modulo DEPTH.
REQ-023 FSM states IDLE, ISSUE, CHECK.
REQ-024 IDLE->ISSUE when FIFO non-empty; otherwise stays IDLE.
REQ-025 ISSUE: start_a/start_b = FIFO head; EN_start = RDY_start (combinational); on EN_start, head is popped, the pair is latched into hold_a/hold_b, next state CHECK.
REQ-026 CHECK: variable__check_d = hold_a; EN_variable__check = RDY_variable__check; on fire, res_data <= variable__check, res_val pulses next cycle, issued_cnt increments, next state ISSUE if FIFO non-empty else IDLE.
REQ-027 EN_start and EN_variable__check are never high together and never high while the corresponding RDY is low.
REQ-028 Minimum transaction period: 2 cycles with both RDYs held high; ISSUE->CHECK->ISSUE back-to-back with no IDLE gap.
REQ-029 start_a, start_b, variable__check_d drive 0 outside ISSUE/CHECK respectively.
REQ-030 An EN_enq while RDY_enq=0 is ignored; FIFO contents unchanged.

Reset
REQ-031 RST_N low, asynchronous: FSM=IDLE, FIFO empty, pointers 0, RDY_enq=1, EN_start=0, EN_variable__check=0, res_val=0, res_data=0, issued_cnt=0, mismatch=0.
REQ-032 Reset mid-transaction discards the FIFO and any held pair; no EN output is asserted until the first cycle after RST_N rises with FIFO non-empty.

Configuration
REQ-033 Macro OPERAND_FEEDER_SELF_CHECK_EN defined: on each check fire, compare variable__check against (hold_a+hold_b) mod 2^W; inequality sets mismatch, cleared only by reset.
REQ-034 Macro undefined: no comparator is built, mismatch tied to 0.

Structure
REQ-035 Shared package holds the FSM state enum (IDLE, ISSUE, CHECK), the default width constant W=6, and the operand-pair struct {a, b}.
REQ-036 One sub-module, operand_fifo (parameterised DEPTH, pair width 2W), holds storage, pointers and occupancy; the FSM lives in operand_feeder.

Verification
REQ-037 Push (a=3,b=5), RDY_start=RDY_variable__check=1, check returns 8 -> EN_start 1 cycle with start_a=3/start_b=5, next cycle EN_variable__check with d=3, res_val with res_data=8, issued_cnt=1, mismatch=0.
REQ-038 Push 4 pairs with RDY_start=0 -> RDY_enq=0 after fourth push, fifth EN_enq ignored; release RDY_start -> exactly 4 transactions issued in order.
REQ-039 RDY_variable__check held 0 for 5 cycles in CHECK -> no EN_variable__check, state stays CHECK, no pop; raise it -> single check fire.
REQ-040 Self-check build: pair (63,1), check returns 5 -> mismatch=1 and stays 1 through later correct results (0 expected).
REQ-041 Assert RST_N=0 during CHECK with 3 pairs queued -> all outputs at reset values immediately; after release, no EN until a new push.
REQ-042 Run 256 transactions -> issued_cnt wraps to 0.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// Shared types and constants for the operand feeder.
// Holds the FSM state enum, the default operand width and the operand-pair struct.
// No logic; imported by the feeder and used by its environment.
package operand_feeder_pkg;

  localparam int W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Handshake bundle between the operand feeder and its upstream/downstream neighbours.
// master: feeder side (enqueue sink, start/check method caller, result source).
// slave: environment side (drives operands, method readiness and the check return value).
interface operand_feeder_if #(parameter int W = operand_feeder_pkg::W);

  logic [W-1:0] enq_a;
  logic [W-1:0] enq_b;
  logic         EN_enq;
  logic         RDY_enq;
  logic [W-1:0] start_a;
  logic [W-1:0] start_b;
  logic         EN_start;
  logic         RDY_start;
  logic [W-1:0] variable__check_d;
  logic         EN_variable__check;
  logic [W-1:0] variable__check;
  logic         RDY_variable__check;
  logic         res_val;
  logic [W-1:0] res_data;
  logic [7:0]   issued_cnt;
  logic         mismatch;

  modport master (
    input  enq_a, enq_b, EN_enq, RDY_start, variable__check, RDY_variable__check,
    output RDY_enq, start_a, start_b, EN_start, variable__check_d, EN_variable__check,
    output res_val, res_data, issued_cnt, mismatch
  );

  modport slave (
    output enq_a, enq_b, EN_enq, RDY_start, variable__check, RDY_variable__check,
    input  RDY_enq, start_a, start_b, EN_start, variable__check_d, EN_variable__check,
    input  res_val, res_data, issued_cnt, mismatch
  );

endinterface

// File: rtl/operand_feeder_fifo.sv
// operand_fifo: circular buffer of DEPTH operand pairs (PW bits each); head is visible combinationally.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: push_rdy comes from registered occupancy only, so a same-cycle pop never raises it.
module operand_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic [PW-1:0] head_dat,
  output logic          not_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_rdy  = (count_q != CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign head_dat  = mem[rd_ptr_q];
  assign push_ok   = push && push_rdy;
  assign pop_ok    = pop && not_empty;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_dat;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Queues operand pairs and drives each through a downstream start call then a check call; optional self-check
// (OPERAND_FEEDER_SELF_CHECK_EN) flags a check value != a+b. Ports: CLK, RST_N, bus (operand_feeder_if.master).
// Latency: 2 cycles per transaction minimum; res_val pulses the cycle after the check fires; stalls on RDY_start/RDY_variable__check.
module operand_feeder #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic               CLK,
  input  logic               RST_N,
  operand_feeder_if.master   bus
);

  import operand_feeder_pkg::*;

  state_t         state_q, state_d;
  logic [W-1:0]   hold_a_q;
  logic [2*W-1:0] head_dat;
  logic           not_empty;
  logic           start_fire;
  logic           check_fire;
  logic [W-1:0]   start_a, start_b, check_d;
  logic           res_val_q;
  logic [W-1:0]   res_data_q;
  logic [7:0]     issued_cnt_q;

  operand_fifo #(.DEPTH(DEPTH), .PW(2*W)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (bus.EN_enq),
    .push_dat  ({bus.enq_a, bus.enq_b}),
    .push_rdy  (bus.RDY_enq),
    .pop       (start_fire),
    .head_dat  (head_dat),
    .not_empty (not_empty)
  );

  always_comb begin
    state_d    = state_q;
    start_a    = '0;
    start_b    = '0;
    start_fire = 1'b0;
    check_d    = '0;
    check_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) state_d = ISSUE;
      end
      ISSUE: begin
        start_a    = head_dat[2*W-1:W];
        start_b    = head_dat[W-1:0];
        // not_empty always holds in ISSUE; kept so a pop can never underflow.
        start_fire = bus.RDY_start && not_empty;
        if (start_fire) state_d = CHECK;
      end
      CHECK: begin
        check_d    = hold_a_q;
        check_fire = bus.RDY_variable__check;
        if (check_fire) state_d = not_empty ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      hold_a_q     <= '0;
      res_val_q    <= 1'b0;
      res_data_q   <= '0;
      issued_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      res_val_q <= check_fire;
      if (start_fire) hold_a_q <= head_dat[2*W-1:W];
      if (check_fire) begin
        res_data_q   <= bus.variable__check;
        issued_cnt_q <= issued_cnt_q + 8'd1;
      end
    end
  end

`ifdef OPERAND_FEEDER_SELF_CHECK_EN
  // b is only needed by the comparator, so it is held only in this build.
  logic [W-1:0] hold_b_q;
  logic [W-1:0] exp_sum;
  logic         mismatch_q;

  assign exp_sum = hold_a_q + hold_b_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_b_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (start_fire) hold_b_q <= head_dat[W-1:0];
      if (check_fire && (bus.variable__check != exp_sum)) mismatch_q <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif

  assign bus.start_a            = start_a;
  assign bus.start_b            = start_b;
  assign bus.EN_start           = start_fire;
  assign bus.variable__check_d  = check_d;
  assign bus.EN_variable__check = check_fire;
  assign bus.res_val            = res_val_q;
  assign bus.res_data           = res_data_q;
  assign bus.issued_cnt         = issued_cnt_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder (DEPTH=4, W=6): reset, single transaction, full FIFO, check stall,
// self-check flag, mid-transaction reset and issued_cnt wrap; expectations are hand-computed.
// Downstream check model returns d + b of the last started pair unless a corrupt value is forced.
module tb_operand_feeder;

  import operand_feeder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic       bad_en;
  logic [5:0] bad_val;
  logic [5:0] last_b;

  operand_pair_t push_q[$];
  operand_pair_t iss_q[$];
  logic [5:0]    sum_q[$];

  operand_feeder_if #(.W(6)) bus();

  operand_feeder #(.DEPTH(4), .W(6)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.EN_start) last_b <= bus.start_b;
  end

  assign bus.variable__check = bad_en ? bad_val : 6'(bus.variable__check_d + last_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [5:0] a, input logic [5:0] b);
    bus.enq_a  = a;
    bus.enq_b  = b;
    bus.EN_enq = 1'b1;
    tick();
    bus.EN_enq = 1'b0;
  endtask

  // Feeds push_q as space allows, checks issue order and results until n results are seen.
  task automatic run(input int n, input int budget);
    int done = 0;
    int cyc  = 0;
    operand_pair_t p;
    while (done < n && cyc < budget) begin
      if (push_q.size() > 0 && bus.RDY_enq) begin
        p = push_q.pop_front();
        bus.enq_a  = p.a;
        bus.enq_b  = p.b;
        bus.EN_enq = 1'b1;
        iss_q.push_back(p);
      end else begin
        bus.EN_enq = 1'b0;
      end
      #1;
      if (bus.EN_start) begin
        if (iss_q.size() == 0) begin
          chk("run_unexpected_start", 32'(bus.EN_start), 32'd0);
        end else begin
          p = iss_q.pop_front();
          chk("run_start_a", 32'(bus.start_a), 32'(p.a));
          chk("run_start_b", 32'(bus.start_b), 32'(p.b));
          sum_q.push_back(6'(p.a + p.b));
        end
      end
      if (bus.res_val) begin
        if (sum_q.size() == 0) begin
          chk("run_unexpected_res", 32'(bus.res_val), 32'd0);
        end else begin
          chk("run_res_data", 32'(bus.res_data), 32'(sum_q.pop_front()));
        end
        done++;
      end
      @(posedge clk);
      #2;
      cyc++;
    end
    bus.EN_enq = 1'b0;
    chk("run_done", 32'(done), 32'(n));
  endtask

  initial begin
    rst_n                   = 1'b0;
    bus.enq_a               = '0;
    bus.enq_b               = '0;
    bus.EN_enq              = 1'b0;
    bus.RDY_start           = 1'b0;
    bus.RDY_variable__check = 1'b0;
    bad_en                  = 1'b0;
    bad_val                 = '0;

    // Reset state
    #12;
    chk("rst_rdy_enq",    32'(bus.RDY_enq), 32'd1);
    chk("rst_en_start",   32'(bus.EN_start), 32'd0);
    chk("rst_en_check",   32'(bus.EN_variable__check), 32'd0);
    chk("rst_res_val",    32'(bus.res_val), 32'd0);
    chk("rst_res_data",   32'(bus.res_data), 32'd0);
    chk("rst_issued_cnt", 32'(bus.issued_cnt), 32'd0);
    chk("rst_mismatch",   32'(bus.mismatch), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single transaction (3,5) -> 8
    bus.RDY_start = 1'b1;
    bus.RDY_variable__check = 1'b1;
    push1(6'd3, 6'd5);
    #1; chk("t1_idle_no_start", 32'(bus.EN_start), 32'd0); tick();
    #1;
    chk("t1_en_start",  32'(bus.EN_start), 32'd1);
    chk("t1_start_a",   32'(bus.start_a), 32'd3);
    chk("t1_start_b",   32'(bus.start_b), 32'd5);
    chk("t1_no_check",  32'(bus.EN_variable__check), 32'd0);
    tick();
    #1;
    chk("t1_en_check",  32'(bus.EN_variable__check), 32'd1);
    chk("t1_check_d",   32'(bus.variable__check_d), 32'd3);
    chk("t1_no_start",  32'(bus.EN_start), 32'd0);
    chk("t1_start_a_0", 32'(bus.start_a), 32'd0);
    tick();
    #1;
    chk("t1_res_val",   32'(bus.res_val), 32'd1);
    chk("t1_res_data",  32'(bus.res_data), 32'd8);
    chk("t1_issued",    32'(bus.issued_cnt), 32'd1);
    chk("t1_mismatch",  32'(bus.mismatch), 32'd0);
    chk("t1_check_d_0", 32'(bus.variable__check_d), 32'd0);
    tick();
    #1; chk("t1_res_pulse", 32'(bus.res_val), 32'd0); tick();

    // Fill FIFO with start stalled; fifth push ignored; drain in order
    bus.RDY_start = 1'b0;
    push1(6'd10, 6'd1); iss_q.push_back('{a: 6'd10, b: 6'd1});
    #1; chk("t2_rdy_after1", 32'(bus.RDY_enq), 32'd1); tick();
    push1(6'd20, 6'd2); iss_q.push_back('{a: 6'd20, b: 6'd2});
    push1(6'd30, 6'd3); iss_q.push_back('{a: 6'd30, b: 6'd3});
    #1; chk("t2_rdy_after3", 32'(bus.RDY_enq), 32'd1); tick();
    push1(6'd40, 6'd4); iss_q.push_back('{a: 6'd40, b: 6'd4});
    #1;
    chk("t2_full",          32'(bus.RDY_enq), 32'd0);
    chk("t2_stalled_start", 32'(bus.EN_start), 32'd0);
    tick();
    push1(6'd50, 6'd5);
    #1; chk("t2_still_full", 32'(bus.RDY_enq), 32'd0); tick();
    bus.RDY_start = 1'b1;
    #1;
    chk("t2_pop_no_rdy", 32'(bus.RDY_enq), 32'd0);
    chk("t2_release",    32'(bus.EN_start), 32'd1);
    run(4, 100);
    #1;
    chk("t2_drained_idle", 32'(bus.EN_start), 32'd0);
    chk("t2_issued",       32'(bus.issued_cnt), 32'd5);
    chk("t2_rdy_enq",      32'(bus.RDY_enq), 32'd1);
    chk("t2_queue_empty",  32'(iss_q.size()), 32'd0);
    tick();

    // Check method stalled for 5 cycles
    bus.RDY_variable__check = 1'b0;
    push1(6'd7, 6'd9);
    tick();
    #1; chk("t3_en_start", 32'(bus.EN_start), 32'd1); tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_no_check", 32'(bus.EN_variable__check), 32'd0);
      chk("t3_stall_in_check", 32'(bus.variable__check_d), 32'd7);
      chk("t3_stall_no_start", 32'(bus.EN_start), 32'd0);
      tick();
    end
    bus.RDY_variable__check = 1'b1;
    #1; chk("t3_check_fire", 32'(bus.EN_variable__check), 32'd1); tick();
    #1;
    chk("t3_res_val",   32'(bus.res_val), 32'd1);
    chk("t3_res_data",  32'(bus.res_data), 32'd16);
    chk("t3_issued",    32'(bus.issued_cnt), 32'd6);
    chk("t3_one_fire",  32'(bus.EN_variable__check), 32'd0);
    tick();

    // Wrong check value (63,1) -> 5: sticky only in the self-check build
    bad_en  = 1'b1;
    bad_val = 6'd5;
    push1(6'd63, 6'd1);
    tick();
    #1; chk("t4_start_a", 32'(bus.start_a), 32'd63); tick();
    #1; chk("t4_en_check", 32'(bus.EN_variable__check), 32'd1); tick();
    #1;
    chk("t4_res_data", 32'(bus.res_data), 32'd5);
`ifdef OPERAND_FEEDER_SELF_CHECK_EN
    chk("t4_mismatch_set", 32'(bus.mismatch), 32'd1);
`else
    chk("t4_mismatch_tied", 32'(bus.mismatch), 32'd0);
`endif
    bad_en = 1'b0;
    tick();
    push_q.push_back('{a: 6'd1, b: 6'd2});
    run(1, 50);
    #1;
`ifdef OPERAND_FEEDER_SELF_CHECK_EN
    chk("t4_mismatch_sticky", 32'(bus.mismatch), 32'd1);
`else
    chk("t4_mismatch_stays0", 32'(bus.mismatch), 32'd0);
`endif
    chk("t4_issued", 32'(bus.issued_cnt), 32'd8);
    tick();

    // Reset while in CHECK with 3 pairs queued
    bus.RDY_variable__check = 1'b0;
    push1(6'd1, 6'd1);
    push1(6'd2, 6'd2);
    push1(6'd3, 6'd3);
    push1(6'd4, 6'd4);
    #1;
    chk("t5_in_check", 32'(bus.variable__check_d), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_en_start", 32'(bus.EN_start), 32'd0);
    chk("t5_rst_en_check", 32'(bus.EN_variable__check), 32'd0);
    chk("t5_rst_check_d",  32'(bus.variable__check_d), 32'd0);
    chk("t5_rst_rdy_enq",  32'(bus.RDY_enq), 32'd1);
    chk("t5_rst_res_val",  32'(bus.res_val), 32'd0);
    chk("t5_rst_res_data", 32'(bus.res_data), 32'd0);
    chk("t5_rst_issued",   32'(bus.issued_cnt), 32'd0);
    chk("t5_rst_mismatch", 32'(bus.mismatch), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.RDY_variable__check = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_quiet_start", 32'(bus.EN_start), 32'd0);
      chk("t5_quiet_check", 32'(bus.EN_variable__check), 32'd0);
      tick();
    end
    push_q.push_back('{a: 6'd9, b: 6'd9});
    run(1, 50);
    #1; chk("t5_issued", 32'(bus.issued_cnt), 32'd1); tick();

    // 255 more transactions: issued_cnt wraps 255 -> 0
    for (int i = 0; i < 255; i++) begin
      push_q.push_back('{a: 6'(i), b: 6'(i * 3)});
    end
    run(255, 3000);
    #1; chk("t6_wrap", 32'(bus.issued_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
